e203_bht_upd_sched: RTL and testbench

- Schedules branch-history-table (BHT) counter updates from the commit stage onto the single-port BHT table RAM.
- Shares that port with IFU prediction lookups.
- Commit-time branch outcomes (bht_wb_*) are queued in a small FIFO, then applied as serialized read-modify-write operations on 2-bit saturating counters.
- Sits between e203_exu_commit (bht outputs) and the IFU BHT storage; the IFU lookup normally has priority.

---
 rtl/e203_bht_pkg.sv | 34 +++
 rtl/e203_bht_upd_fifo.sv | 56 +++++
 rtl/e203_bht_upd_sched.sv | 136 +++++++++++++
 tb/tb_e203_bht_upd_sched.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/e203_bht_pkg.sv
// Shared types and constants for the BHT update scheduler: FSM states,
// 2-bit counter encodings, pending-update entry and the saturating-counter step.
package e203_bht_pkg;

  localparam int unsigned BHT_PC_SIZE    = 32;
  localparam int unsigned BHT_FIFO_DEPTH = 4;
  localparam int unsigned IDX_W          = 8;
  localparam int unsigned CNT_W          = 2;

  localparam logic [CNT_W-1:0] SNT = CNT_W'(0);
  localparam logic [CNT_W-1:0] WNT = CNT_W'(1);
  localparam logic [CNT_W-1:0] WT  = CNT_W'(2);
  localparam logic [CNT_W-1:0] ST  = CNT_W'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2
  } bht_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             rslv;
    logic             mis;
  } bht_upd_t;

  // Step a 2-bit counter toward the resolved direction, clamped at SNT/ST.
  function automatic logic [CNT_W-1:0] bht_sat(input logic [CNT_W-1:0] cnt,
                                               input logic             taken);
    if (taken) return (cnt == ST) ? ST : cnt + CNT_W'(1);
    return (cnt == SNT) ? SNT : cnt - CNT_W'(1);
  endfunction

endpackage

// File: rtl/e203_bht_upd_fifo.sv
// Pending-update FIFO: power-of-two depth, wrapping pointers, push accepted
// while full when a pop happens in the same cycle.
module e203_bht_upd_fifo
  import e203_bht_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  bht_upd_t      din,
  input  logic          pop,
  output bht_upd_t      dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  bht_upd_t      mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign count   = cnt_q;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/e203_bht_upd_sched.sv
// Serialises commit-time BHT counter updates as read-modify-write operations
// on the single-port table, yielding to IFU lookups unless the queue is full.
module e203_bht_upd_sched
  import e203_bht_pkg::*;
#(
  parameter int unsigned PC_SIZE    = BHT_PC_SIZE,
  parameter int unsigned FIFO_DEPTH = BHT_FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wb_vld,
  input  logic [PC_SIZE-1:0] wb_pc,
  input  logic               wb_rslv,
  input  logic               wb_mis,
  input  logic               lkup_req,
  input  logic [IDX_W-1:0]   lkup_idx,
  output logic               lkup_gnt,
  output logic               lkup_rvld,
  output logic [CNT_W-1:0]   lkup_rdata,
  output logic               tbl_en,
  output logic               tbl_we,
  output logic [IDX_W-1:0]   tbl_idx,
  output logic [CNT_W-1:0]   tbl_wdata,
  input  logic [CNT_W-1:0]   tbl_rdata,
  output logic               upd_pend,
  output logic               upd_drop,
  output logic [15:0]        mis_cnt
);

  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned MIS_W = 16;

  bht_state_e       state_q;
  bht_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [MIS_W-1:0] mis_q;
  logic             rvld_q;

  bht_upd_t         wb_ent;
  bht_upd_t         head;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [FCW-1:0]   fifo_cnt;

  logic             starve;
  logic             upd_go;
  logic             rd_issue;
  logic             wr_issue;
  logic             unused_pc;

  // RVC-aligned index: bit 0 of the PC never selects an entry.
  assign wb_ent    = '{idx: wb_pc[IDX_W:1], rslv: wb_rslv, mis: wb_mis};
  assign unused_pc = ^{wb_pc[PC_SIZE-1:IDX_W+1], wb_pc[0]};

  assign fifo_push = rst_n & wb_vld;
  assign fifo_pop  = wr_issue;

  e203_bht_upd_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .din   (wb_ent),
    .pop   (fifo_pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  // A full queue takes the port away from lookups except during the RD slot.
  assign starve   = fifo_full & ((state_q == S_IDLE) | (state_q == S_WR));
  assign upd_go   = rst_n & (~lkup_req | starve);
  assign upd_drop = fifo_push & fifo_full & ~fifo_pop;
  assign upd_pend = (fifo_cnt != '0) | (state_q != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (~fifo_empty & upd_go) state_d = S_RD;
      S_RD:    state_d = S_WR;
      S_WR:    if (upd_go) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_issue  = 1'b0;
    wr_issue  = 1'b0;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_idx   = '0;
    tbl_wdata = '0;
    case (state_q)
      S_IDLE:  rd_issue = ~fifo_empty & upd_go;
      S_WR:    wr_issue = upd_go;
      default: ;
    endcase
    lkup_gnt = rst_n & lkup_req & ~(rd_issue | wr_issue) & ~starve;
    if (rd_issue | wr_issue) begin
      tbl_en    = 1'b1;
      tbl_we    = wr_issue;
      tbl_idx   = head.idx;
      tbl_wdata = wr_issue ? cnt_q : '0;
    end else if (lkup_gnt) begin
      tbl_en  = 1'b1;
      tbl_idx = lkup_idx;
    end
  end

  // RMW datapath, lookup-valid pipe and saturating mispredict counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mis_q  <= '0;
      rvld_q <= 1'b0;
    end else begin
      rvld_q <= lkup_gnt;
      if (state_q == S_RD) cnt_q <= bht_sat(tbl_rdata, head.rslv);
      if (wr_issue & head.mis & (mis_q != '1)) mis_q <= mis_q + MIS_W'(1);
    end
  end

  assign lkup_rvld  = rvld_q;
  assign lkup_rdata = rvld_q ? tbl_rdata : '0;
  assign mis_cnt    = mis_q;

endmodule

// File: tb/tb_e203_bht_upd_sched.sv
// Bench for e203_bht_upd_sched: table RAM model, transaction-level reference
// (pending queue + golden counters) checked every cycle, plus directed scenarios.
module tb_e203_bht_upd_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wb_vld = 1'b0;
  logic [31:0] wb_pc = '0;
  logic        wb_rslv = 1'b0;
  logic        wb_mis = 1'b0;
  logic        lkup_req = 1'b0;
  logic [7:0]  lkup_idx = '0;
  logic        lkup_gnt;
  logic        lkup_rvld;
  logic [1:0]  lkup_rdata;
  logic        tbl_en;
  logic        tbl_we;
  logic [7:0]  tbl_idx;
  logic [1:0]  tbl_wdata;
  logic [1:0]  tbl_rdata = '0;
  logic        upd_pend;
  logic        upd_drop;
  logic [15:0] mis_cnt;

  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [1:0]  pre_val = '0;
  logic [1:0]  ram [256];

  int unsigned n_pass = 0;
  int unsigned n_chk  = 0;
  int unsigned n_wr   = 0;

  e203_bht_upd_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb_vld     (wb_vld),
    .wb_pc      (wb_pc),
    .wb_rslv    (wb_rslv),
    .wb_mis     (wb_mis),
    .lkup_req   (lkup_req),
    .lkup_idx   (lkup_idx),
    .lkup_gnt   (lkup_gnt),
    .lkup_rvld  (lkup_rvld),
    .lkup_rdata (lkup_rdata),
    .tbl_en     (tbl_en),
    .tbl_we     (tbl_we),
    .tbl_idx    (tbl_idx),
    .tbl_wdata  (tbl_wdata),
    .tbl_rdata  (tbl_rdata),
    .upd_pend   (upd_pend),
    .upd_drop   (upd_drop),
    .mis_cnt    (mis_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous single-port table with a side preload port.
  always @(posedge clk) begin
    if (pre_en) ram[pre_idx] <= pre_val;
    else if (tbl_en) begin
      if (tbl_we) ram[tbl_idx] <= tbl_wdata;
      else        tbl_rdata    <= ram[tbl_idx];
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
  endtask

  function automatic int sat_ref(input int c, input bit taken);
    if (taken) return (c >= 3) ? 3 : c + 1;
    return (c <= 0) ? 0 : c - 1;
  endfunction

  typedef struct {
    int idx;
    bit rslv;
    bit mis;
  } ent_t;

  ent_t q[$];
  int   model_tbl [256];
  int   model_mis = 0;
  bit   prev_gnt = 1'b0;
  int   prev_gnt_val = 0;
  bit   prev_upd_rd = 1'b0;

  // Reference: the queue holds every accepted, not-yet-written update in order.
  always @(negedge clk) begin
    bit   full, exp_gnt, is_wr, is_urd, exp_drop;
    int   exp_w;
    ent_t e;
    if (pre_en) model_tbl[pre_idx] = int'(pre_val);
    if (!rst_n) begin
      chk("cmp_rst_port", {tbl_en, tbl_we}, 2'b00);
      q.delete();
      model_mis    = 0;
      prev_gnt     = 1'b0;
      prev_upd_rd  = 1'b0;
    end else begin
      chk("cmp_rvld", lkup_rvld, prev_gnt);
      if (prev_gnt) chk("cmp_rdata", lkup_rdata, prev_gnt_val);
      chk("cmp_mis", mis_cnt, model_mis);
      chk("cmp_pend", upd_pend, q.size() != 0);
      full    = (q.size() == 4);
      exp_gnt = lkup_req && (!full || prev_upd_rd);
      chk("cmp_gnt", lkup_gnt, exp_gnt);
      if (lkup_gnt) chk("cmp_gnt_port", {tbl_en, tbl_we, tbl_idx}, {1'b1, 1'b0, lkup_idx});
      is_wr  = tbl_en && tbl_we;
      is_urd = tbl_en && !tbl_we && !lkup_gnt;
      if (is_urd) begin
        if (q.size() == 0) chk("cmp_rd_unexp", q.size(), 1);
        else chk("cmp_rd_idx", tbl_idx, q[0].idx);
      end
      if (is_wr) begin
        n_wr++;
        if (q.size() == 0) chk("cmp_wr_unexp", q.size(), 1);
        else begin
          exp_w = sat_ref(model_tbl[q[0].idx], q[0].rslv);
          chk("cmp_wr", {tbl_idx, tbl_wdata}, {8'(q[0].idx), 2'(exp_w)});
          model_tbl[q[0].idx] = exp_w;
          if (q[0].mis && model_mis < 16'hFFFF) model_mis++;
          void'(q.pop_front());
        end
      end
      exp_drop = wb_vld && full && !is_wr;
      chk("cmp_drop", upd_drop, exp_drop);
      if (wb_vld && !exp_drop) begin
        e.idx  = int'(wb_pc[8:1]);
        e.rslv = wb_rslv;
        e.mis  = wb_mis;
        q.push_back(e);
      end
      prev_gnt     = lkup_gnt;
      prev_gnt_val = int'(ram[lkup_idx]);
      prev_upd_rd  = is_urd;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [1:0] val);
    pre_en  = 1'b1;
    pre_idx = idx;
    pre_val = val;
    tick();
    pre_en  = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic rslv, input logic mis);
    wb_vld  = 1'b1;
    wb_pc   = pc;
    wb_rslv = rslv;
    wb_mis  = mis;
    tick();
    wb_vld  = 1'b0;
  endtask

  task automatic wait_wr(input string nm, input int exp_idx, input int exp_d);
    bit found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      look();
      if (tbl_en && tbl_we) begin
        found = 1'b1;
        chk(nm, {tbl_idx, tbl_wdata}, {8'(exp_idx), 2'(exp_d)});
      end
      tick();
    end
    if (!found) chk({nm, "_timeout"}, found, 1'b1);
  endtask

  initial begin
    int wr0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    look();
    chk("reset_outs", {lkup_gnt, lkup_rvld, lkup_rdata, tbl_en, tbl_we, tbl_idx,
                       tbl_wdata, upd_pend, upd_drop, mis_cnt}, '0);
    tick();

    // Single taken update on idx 8 (counter 1 -> 2), read +1, write +3.
    preload(8'h08, 2'd1);
    wb_vld = 1'b1; wb_pc = 32'h0000_0010; wb_rslv = 1'b1; wb_mis = 1'b1;
    look(); chk("t1_pend_before", upd_pend, 1'b0);
    tick(); wb_vld = 1'b0;
    look(); chk("t1_rd", {tbl_en, tbl_we, tbl_idx}, {1'b1, 1'b0, 8'h08});
    chk("t1_pend", upd_pend, 1'b1);
    tick(); look(); chk("t1_rd_gap", tbl_en, 1'b0);
    tick(); look(); chk("t1_wr", {tbl_en, tbl_we, tbl_idx, tbl_wdata}, {1'b1, 1'b1, 8'h08, 2'd2});
    tick(); look(); chk("t1_done", {upd_pend, mis_cnt}, {1'b0, 16'd1});
    tick();

    // Saturation at both ends.
    preload(8'h05, 2'd3);
    push(32'h0000_000A, 1'b1, 1'b0);
    wait_wr("t2_sat_hi", 5, 3);
    preload(8'h05, 2'd0);
    push(32'h0000_000A, 1'b0, 1'b0);
    wait_wr("t2_sat_lo", 5, 0);

    // Lookups hold the port while the queue is not full.
    preload(8'h20, 2'd2);
    preload(8'h40, 2'd0);
    lkup_idx = 8'h20; lkup_req = 1'b1;
    push(32'h0000_0080, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      look();
      chk("t3_gnt", {lkup_gnt, tbl_we, tbl_idx}, {1'b1, 1'b0, 8'h20});
      chk("t3_rdata", {lkup_rvld, lkup_rdata}, {1'b1, 2'd2});
      tick();
    end
    lkup_req = 1'b0;
    look(); chk("t3_rd", {tbl_en, tbl_we, tbl_idx}, {1'b1, 1'b0, 8'h40});
    tick(); look(); chk("t3_gap", tbl_en, 1'b0);
    tick(); look(); chk("t3_wr", {tbl_en, tbl_we, tbl_idx, tbl_wdata}, {1'b1, 1'b1, 8'h40, 2'd1});
    tick();

    // Full queue starves lookups; a fifth update with no pop is dropped.
    for (int k = 0; k < 4; k++) preload(8'(8'h50 + k), 2'd1);
    wr0 = int'(n_wr);
    lkup_idx = 8'h20; lkup_req = 1'b1;
    for (int k = 0; k < 4; k++) push(32'h0000_00A0 + 32'(2 * k), 1'b1, 1'b0);
    wb_vld = 1'b1; wb_pc = 32'h0000_00C0; wb_rslv = 1'b1; wb_mis = 1'b0;
    look();
    chk("t4_starve_gnt", lkup_gnt, 1'b0);
    chk("t4_starve_rd", {tbl_en, tbl_we, tbl_idx}, {1'b1, 1'b0, 8'h50});
    chk("t4_drop", upd_drop, 1'b1);
    tick(); wb_vld = 1'b0; lkup_req = 1'b0;
    look(); chk("t4_drop_pulse", upd_drop, 1'b0);
    for (int i = 0; i < 60 && upd_pend; i++) begin
      tick(); look();
    end
    chk("t4_drain", upd_pend, 1'b0);
    chk("t4_nwr", int'(n_wr) - wr0, 4);
    chk("t4_tbl", {ram[8'h50], ram[8'h51], ram[8'h52], ram[8'h53]}, 8'b10_10_10_10);
    tick();

    // Back-to-back updates to idx 3 serialise: 0 -> 1 -> 2.
    preload(8'h03, 2'd0);
    push(32'h0000_0006, 1'b1, 1'b1);
    push(32'h0000_0006, 1'b1, 1'b0);
    wait_wr("t5_wr1", 3, 1);
    wait_wr("t5_wr2", 3, 2);
    look(); chk("t5_mis", mis_cnt, 16'd2);
    tick();

    // Reset while the RMW waits in its write slot abandons the write.
    preload(8'h70, 2'd1);
    push(32'h0000_00E0, 1'b1, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    look(); chk("t6_rst_nowr", {tbl_en, tbl_we}, 2'b00);
    tick(); rst_n = 1'b1;
    look();
    chk("t6_rst_outs", {lkup_gnt, lkup_rvld, lkup_rdata, tbl_en, tbl_we, tbl_idx,
                        tbl_wdata, upd_pend, upd_drop, mis_cnt}, '0);
    chk("t6_tbl_kept", ram[8'h70], 2'd1);
    tick(); look(); chk("t6_idle", {upd_pend, tbl_en}, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_chk);
    $fatal(1);
  end

endmodule
